biquinary_word_adder_seq: RTL and testbench

- Sequencing controller that adds two multi-digit bi-quinary words one digit per clock, least-significant digit first.
- Uses a single shared digit-adder stage and a registered carry.
- Sits between the register file/accumulator logic and the decimal datapath; serves as the word-level add engine for character/decimal arithmetic.
- Adds carry-in handling around the digit adder, which itself ignores its carry input.

---
 rtl/biquinary_word_adder_seq.sv | 177 +++++++++++++++++
 tb/tb_biquinary_word_adder_seq.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/biquinary_word_adder_seq.sv
// Word-level bi-quinary adder: one digit per clock through a shared digit adder,
// least-significant digit first, with a registered carry between digits.
module biquinary_word_adder_seq #(
    parameter int DIGITS = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [6*DIGITS-1:0]   a,
    input  logic [6*DIGITS-1:0]   b,
    input  logic                  cin,
    output logic                  busy,
    output logic                  done,
    output logic [6*DIGITS-1:0]   sum,
    output logic                  cout,
    output logic                  err
);

    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                state_r;
    logic [6*DIGITS-1:0]   a_r;
    logic [6*DIGITS-1:0]   b_r;
    logic                  carry_r;
    logic [IDX_W-1:0]      idx_r;

    logic [5:0]            op_a_s;
    logic [5:0]            op_b_s;
    logic [4:0]            pair_sum_s;
    logic [5:0]            pair_digit_s;
    logic                  pair_carry_s;
    logic [5:0]            step_digit_s;
    logic                  inc_carry_s;
    logic                  step_carry_s;
    logic                  malformed_s;

    function automatic logic digit_ok(input logic [5:0] dg);
        return (dg[4:0] != 5'd0) && ((dg[4:0] & (dg[4:0] - 5'd1)) == 5'd0);
    endfunction

    // Malformed digits decode to 0 so the operation can still complete.
    function automatic logic [3:0] digit_val(input logic [5:0] dg);
        logic [3:0] q_v;
        logic       ok_v;
        ok_v = 1'b1;
        case (dg[4:0])
            5'b00001: q_v = 4'd0;
            5'b00010: q_v = 4'd1;
            5'b00100: q_v = 4'd2;
            5'b01000: q_v = 4'd3;
            5'b10000: q_v = 4'd4;
            default: begin
                q_v  = 4'd0;
                ok_v = 1'b0;
            end
        endcase
        if (!ok_v) begin
            return 4'd0;
        end else begin
            return dg[5] ? (q_v + 4'd5) : q_v;
        end
    endfunction

    function automatic logic [5:0] digit_enc(input logic [3:0] v);
        case (v)
            4'd0:    return 6'b000001;
            4'd1:    return 6'b000010;
            4'd2:    return 6'b000100;
            4'd3:    return 6'b001000;
            4'd4:    return 6'b010000;
            4'd5:    return 6'b100001;
            4'd6:    return 6'b100010;
            4'd7:    return 6'b100100;
            4'd8:    return 6'b101000;
            4'd9:    return 6'b110000;
            default: return 6'b000001;
        endcase
    endfunction

    // Shared digit adder (carry-less) followed by the carry-in quinary rotate.
    always_comb begin
        op_a_s       = a_r[int'(idx_r)*6 +: 6];
        op_b_s       = b_r[int'(idx_r)*6 +: 6];
        malformed_s  = !digit_ok(op_a_s) || !digit_ok(op_b_s);
        pair_sum_s   = {1'b0, digit_val(op_a_s)} + {1'b0, digit_val(op_b_s)};
        pair_carry_s = 1'b0;
        pair_digit_s = 6'b000001;
        if (pair_sum_s >= 5'd10) begin
            pair_carry_s = 1'b1;
            pair_digit_s = digit_enc(4'(pair_sum_s - 5'd10));
        end else begin
            pair_carry_s = 1'b0;
            pair_digit_s = digit_enc(pair_sum_s[3:0]);
        end
        step_digit_s = pair_digit_s;
        inc_carry_s  = 1'b0;
        if (carry_r) begin
            if (pair_digit_s[4]) begin
                step_digit_s = {~pair_digit_s[5], 5'b00001};
                inc_carry_s  = pair_digit_s[5];
            end else begin
                step_digit_s = {pair_digit_s[5], pair_digit_s[3:0], 1'b0};
                inc_carry_s  = 1'b0;
            end
        end else begin
            step_digit_s = pair_digit_s;
            inc_carry_s  = 1'b0;
        end
        step_carry_s = pair_carry_s | inc_carry_s;
    end

    // Sequencer: latch operands, walk the digits, then publish cout and pulse done.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            a_r     <= '0;
            b_r     <= '0;
            carry_r <= 1'b0;
            idx_r   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            cout    <= 1'b0;
            err     <= 1'b0;
            sum     <= {DIGITS{6'b000001}};
        end else begin
            done <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (start) begin
                        a_r     <= a;
                        b_r     <= b;
                        carry_r <= cin;
                        err     <= 1'b0;
                        idx_r   <= '0;
                        busy    <= 1'b1;
                        state_r <= RUN;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                RUN: begin
                    sum[int'(idx_r)*6 +: 6] <= step_digit_s;
                    carry_r <= step_carry_s;
                    if (malformed_s) begin
                        err <= 1'b1;
                    end else begin
                        err <= err;
                    end
                    if (idx_r == LAST_IDX) begin
                        busy    <= 1'b0;
                        state_r <= DONE;
                    end else begin
                        idx_r   <= idx_r + {{(IDX_W-1){1'b0}}, 1'b1};
                        state_r <= RUN;
                    end
                end
                DONE: begin
                    done    <= 1'b1;
                    cout    <= carry_r;
                    state_r <= IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_biquinary_word_adder_seq.sv
// Self-checking bench for biquinary_word_adder_seq: directed plan cases plus
// randomized operands, compared every cycle against a decimal-arithmetic model.
module tb_biquinary_word_adder_seq;

    localparam int DIGITS = 10;
    localparam int W      = 6 * DIGITS;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
    logic         err;

    int total = 0;
    int bad   = 0;
    int done_cnt = 0;

    biquinary_word_adder_seq #(.DIGITS(DIGITS)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
        .busy(busy), .done(done), .sum(sum), .cout(cout), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [5:0] enc(input int v);
        logic [4:0] q;
        q = 5'b00001 << (v % 5);
        return {(v >= 5) ? 1'b1 : 1'b0, q};
    endfunction

    // Returns -1 for a digit whose quinary part is not one-hot.
    function automatic int dec(input logic [5:0] dg);
        int pos;
        if ($countones(dg[4:0]) != 1) return -1;
        pos = 0;
        for (int k = 0; k < 5; k++) if (dg[k]) pos = k;
        return 5 * int'(dg[5]) + pos;
    endfunction

    function automatic logic [W-1:0] fill(input int v);
        logic [W-1:0] w;
        for (int i = 0; i < DIGITS; i++) w[6*i +: 6] = enc(v);
        return w;
    endfunction

    function automatic logic [W-1:0] rnd_word();
        logic [W-1:0] w;
        for (int i = 0; i < DIGITS; i++) begin
            if ($urandom_range(0, 7) == 0) w[6*i +: 6] = 6'($urandom);
            else                           w[6*i +: 6] = enc($urandom_range(0, 9));
        end
        return w;
    endfunction

    task automatic model_add(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci,
                             output logic [W-1:0] s, output logic co, output logic e);
        int c, vx, vy, d;
        c = int'(ci);
        e = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            vx = dec(x[6*i +: 6]);
            vy = dec(y[6*i +: 6]);
            if (vx < 0) begin e = 1'b1; vx = 0; end
            if (vy < 0) begin e = 1'b1; vy = 0; end
            d = vx + vy + c;
            s[6*i +: 6] = enc(d % 10);
            c = d / 10;
        end
        co = (c != 0);
    endtask

    // Model position: edges since the accepting edge, -1 when no operation is live.
    int           ph = -1;
    logic         model_on = 1'b0;
    logic [W-1:0] res_sum, shown_sum;
    logic         res_cout, shown_cout, res_err, shown_err;

    initial begin
        forever begin
            @(negedge clk);
            if (model_on) begin
                chk("busy", busy, (ph >= 0 && ph < DIGITS));
                chk("done", done, (ph == DIGITS + 1));
                chk("cout", cout, shown_cout);
                if (ph < 0 || ph >= DIGITS) begin
                    chk("sum", sum, shown_sum);
                    chk("err", err, shown_err);
                end
                if (done === 1'b1) done_cnt++;
            end
            if (rst) begin
                model_on   = 1'b1;
                ph         = -1;
                shown_sum  = fill(0);
                shown_cout = 1'b0;
                shown_err  = 1'b0;
            end else if (model_on) begin
                if (start && (ph < 0 || ph == DIGITS + 1)) begin
                    ph = 0;
                    model_add(a, b, cin, res_sum, res_cout, res_err);
                end else if (ph >= 0) begin
                    ph++;
                    if (ph == DIGITS) begin
                        shown_sum = res_sum;
                        shown_err = res_err;
                    end
                    if (ph == DIGITS + 1) shown_cout = res_cout;
                    if (ph > DIGITS + 1) ph = -1;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(output int busy_cnt);
        logic found;
        found    = 1'b0;
        busy_cnt = 0;
        for (int k = 0; k < DIGITS + 6; k++) begin
            @(negedge clk);
            if (busy === 1'b1) busy_cnt++;
            if (done === 1'b1) begin
                found = 1'b1;
                break;
            end
        end
        chk("done_within_budget", found, 1'b1);
    endtask

    task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci,
                          output int busy_cnt);
        tick();
        a = x; b = y; cin = ci; start = 1'b1;
        tick();
        start = 1'b0;
        a = rnd_word(); b = rnd_word(); cin = ~ci;
        wait_done(busy_cnt);
    endtask

    logic [W-1:0] ms;
    logic         mc, me;
    logic [W-1:0] w;
    int           bc, d0;

    initial begin
        rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        tick(); tick(); tick();
        chk("reset_sum", sum, {DIGITS{6'b000001}});
        chk("reset_flags", {busy, done, cout, err}, 4'b0000);
        rst = 1'b0;

        // Pin the model itself against hand-computed words.
        model_add(fill(1), fill(7), 1'b0, ms, mc, me);
        chk("model_1p7", {ms, mc, me}, {{DIGITS{6'b101000}}, 1'b0, 1'b0});
        model_add(fill(9), fill(0), 1'b1, ms, mc, me);
        chk("model_ripple", {ms, mc, me}, {{DIGITS{6'b000001}}, 1'b1, 1'b0});

        run_op(fill(1), fill(7), 1'b0, bc);
        chk("t1_sum", sum, {DIGITS{6'b101000}});
        chk("t1_cout_err", {cout, err}, 2'b00);
        chk("t1_busy_cycles", bc, DIGITS);

        run_op(fill(9), fill(0), 1'b1, bc);
        chk("t2_sum", sum, {DIGITS{6'b000001}});
        chk("t2_cout", cout, 1'b1);

        w = fill(0); w[5:0] = 6'b110000;
        run_op(w, w, 1'b1, bc);
        chk("t3_sum", sum, {{(DIGITS-2){6'b000001}}, 6'b000010, 6'b110000});
        chk("t3_cout", cout, 1'b0);

        // start held through RUN with changing operands
        d0 = done_cnt;
        tick();
        a = fill(1); b = fill(7); cin = 1'b0; start = 1'b1;
        for (int j = 0; j <= DIGITS; j++) begin
            tick();
            if (j < DIGITS) begin
                a = rnd_word(); b = rnd_word(); cin = 1'($urandom); start = 1'b1;
            end else begin
                start = 1'b0;
            end
        end
        wait_done(bc);
        chk("t4_sum", sum, {DIGITS{6'b101000}});
        for (int j = 0; j < 4; j++) tick();
        chk("t4_done_pulses", done_cnt - d0, 1);

        // reset while digit 4 is being processed
        tick();
        a = fill(3); b = fill(4); cin = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        for (int j = 0; j < 4; j++) tick();
        rst = 1'b1; start = 1'b1;
        tick();
        rst = 1'b0; start = 1'b0;
        chk("t5_busy", busy, 1'b0);
        chk("t5_sum", sum, {DIGITS{6'b000001}});
        d0 = done_cnt;
        for (int j = 0; j < DIGITS + 4; j++) tick();
        chk("t5_no_done", done_cnt - d0, 0);
        run_op(fill(2), fill(2), 1'b0, bc);
        chk("t5_fresh_sum", sum, {DIGITS{6'b010000}});

        w = fill(2); w[23:18] = 6'b000011;
        run_op(w, fill(3), 1'b0, bc);
        chk("t6_sum", sum, {{(DIGITS-4){6'b100001}}, 6'b001000, {3{6'b100001}}});
        chk("t6_err", err, 1'b1);
        run_op(fill(1), fill(7), 1'b0, bc);
        chk("t6_err_clear", err, 1'b0);

        // randomized operations, some back-to-back, with start noise during RUN
        d0 = done_cnt;
        tick();
        for (int op = 0; op < 30; op++) begin
            a = rnd_word(); b = rnd_word(); cin = 1'($urandom); start = 1'b1;
            tick();
            for (int j = 0; j < DIGITS + 1 + int'($urandom_range(0, 2)); j++) begin
                if (j < DIGITS - 1) begin
                    start = 1'($urandom);
                    a = rnd_word(); b = rnd_word(); cin = 1'($urandom);
                end else begin
                    start = 1'b0;
                end
                tick();
            end
        end
        start = 1'b0;
        for (int j = 0; j < DIGITS + 4; j++) tick();
        chk("rand_done_count", done_cnt - d0, 30);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
